// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle shared by the fetch port, the load/store port and the
// single memory port. master = arbiter side, slave = requesters + memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [31:0]       if_resp_data;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [63:0]       ls_wdata;
    logic [7:0]        ls_wmask;
    logic              ls_resp_valid;
    logic [63:0]       ls_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [63:0]       mem_resp_data;

    modport master (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_resp_valid, ls_resp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_resp_valid, ls_resp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store
// (LS). Ports: clk, rst (async, active-high), bus (master modport of
// mem_port_arbiter_if), busy (request outstanding), conflict_cnt (perf count).
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus,
    output logic                busy,
    output logic [31:0]         conflict_cnt
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   starve_q;
    logic [31:0]        conflict_q;
    logic               half_q;

    logic               idle;
    logic               starved;
    logic               sel_ls;
    logic               sel_if;
    logic               acc_ls;
    logic               acc_if;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^bus.if_addr[1:0];

    // Selection is only meaningful in IDLE and is masked during reset so
    // every handshake output reads 0 while rst is held.
    assign idle    = (state_q == IDLE) && !rst;
    assign starved = bus.if_req_valid &&
                     (starve_q == CNT_W'(STARVE_LIMIT));
    assign sel_ls  = idle && bus.ls_req_valid && !starved;
    assign sel_if  = idle && !sel_ls && bus.if_req_valid;
    assign acc_ls  = sel_ls && bus.mem_req_ready;
    assign acc_if  = sel_if && bus.mem_req_ready;

    assign bus.ls_req_ready  = acc_ls;
    assign bus.if_req_ready  = acc_if;
    assign bus.mem_req_valid = sel_ls || sel_if;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        if (sel_ls) begin
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wen   = bus.ls_wen;
            bus.mem_wdata = bus.ls_wdata;
            bus.mem_wmask = bus.ls_wmask;
        end else if (sel_if) begin
            // Fetch reads the whole doubleword; the half bit picks the word.
            bus.mem_addr = {bus.if_addr[ADDR_W-1:3], 3'b000};
        end
    end

    // Responses in IDLE are strays (e.g. after a reset) and are dropped.
    assign bus.if_resp_valid = (state_q == WAIT_IF) && bus.mem_resp_valid;
    assign bus.ls_resp_valid = (state_q == WAIT_LS) && bus.mem_resp_valid;

    assign bus.if_resp_data = !bus.if_resp_valid ? 32'd0 :
                              half_q ? bus.mem_resp_data[63:32] :
                                       bus.mem_resp_data[31:0];
    assign bus.ls_resp_data = bus.ls_resp_valid ?
                              bus.mem_resp_data[DATA_W-1:0] : 64'd0;

    assign busy         = (state_q != IDLE);
    assign conflict_cnt = conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            conflict_q <= '0;
            half_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.if_req_valid && bus.ls_req_valid)
                        conflict_q <= conflict_q + 32'd1;
                    if (acc_ls) begin
                        state_q <= WAIT_LS;
                        if (bus.if_req_valid &&
                            starve_q != CNT_W'(STARVE_LIMIT))
                            starve_q <= starve_q + 1'b1;
                    end else if (acc_if) begin
                        state_q  <= WAIT_IF;
                        half_q   <= bus.if_addr[2];
                        starve_q <= '0;
                    end
                end
                WAIT_IF, WAIT_LS: begin
                    if (bus.mem_resp_valid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario,
// inline comparisons, single summary line.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [31:0] conflict_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .CNT_W(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wen         = 1'b0;
        bus.ls_wdata       = '0;
        bus.ls_wmask       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt);
        end
        n_checks++;
        if ({bus.mem_req_valid, bus.if_req_ready, bus.ls_req_ready,
             bus.if_resp_valid, bus.ls_resp_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valids: got nonzero want 0");
        end
        n_checks++;
        if (bus.mem_addr !== 64'd0 || bus.ls_resp_data !== 64'd0 ||
            bus.if_resp_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: got mem_addr %h want 0", bus.mem_addr);
        end
    endtask

    task automatic test_if_only();
        int nb = 0;
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0004;
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_addr !== 64'h8000_0000 || bus.mem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL if_addr: got %h want 80000000", bus.mem_addr);
        end
        n_checks++;
        if (bus.if_req_ready !== 1'b1 || bus.mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL if_ready: got %b want 1", bus.if_req_ready);
        end
        tick();
        bus.if_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 64'hAABBCCDD_11223344;
            end
            #1;
            if (busy) nb++;
            if (i == 2) begin
                n_checks++;
                if (bus.if_resp_valid !== 1'b1 ||
                    bus.if_resp_data !== 32'hAABBCCDD) begin
                    n_fail++;
                    $display("FAIL if_resp: got %b/%h want 1/aabbccdd",
                             bus.if_resp_valid, bus.if_resp_data);
                end
            end
            tick();
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
        end
        #1;
        n_checks++;
        if (nb !== 3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL if_busy: got %0d cycles/busy %b want 3/0", nb, busy);
        end
        n_checks++;
        if (bus.if_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL if_pulse: got %b want 0", bus.if_resp_valid);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0010;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_1000;
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0 ||
            bus.mem_addr !== 64'h8000_1000) begin
            n_fail++;
            $display("FAIL sim_grant: got ls %b if %b addr %h want 1 0 80001000",
                     bus.ls_req_ready, bus.if_req_ready, bus.mem_addr);
        end
        tick();
        bus.ls_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h1122334455667788;
        #1;
        n_checks++;
        if (conflict_cnt !== 32'd1) begin
            n_fail++; $display("FAIL sim_conflict: got %0d want 1", conflict_cnt);
        end
        n_checks++;
        if (bus.ls_resp_valid !== 1'b1 ||
            bus.ls_resp_data !== 64'h1122334455667788 ||
            bus.if_resp_valid !== 1'b0 || bus.if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL sim_ls_resp: got %b %h want 1 1122334455667788",
                               bus.ls_resp_valid, bus.ls_resp_data);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        #1;
        n_checks++;
        if (bus.if_req_ready !== 1'b1 || bus.mem_addr !== 64'h8000_0010) begin
            n_fail++; $display("FAIL sim_if_grant: got %b %h want 1 80000010",
                               bus.if_req_ready, bus.mem_addr);
        end
        tick();
        bus.if_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hCAFEF00D_0BADBEEF;
        #1;
        n_checks++;
        if (bus.if_resp_valid !== 1'b1 || bus.if_resp_data !== 32'h0BADBEEF) begin
            n_fail++; $display("FAIL sim_if_low: got %h want 0badbeef", bus.if_resp_data);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_starvation();
        logic [4:0] grants = '0;
        logic [4:0] want   = 5'b10000;
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0020;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_3000;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            grants[k] = bus.if_req_ready;
            n_checks++;
            if ((bus.if_req_ready ^ bus.ls_req_ready) !== 1'b1) begin
                n_fail++; $display("FAIL starve_onehot%0d: got if %b ls %b want one",
                                   k, bus.if_req_ready, bus.ls_req_ready);
            end
            tick();
            if (k == 4) bus.if_req_valid = 1'b0;
            bus.mem_resp_valid = 1'b1;
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        bus.ls_req_valid = 1'b0;
        #1;
        n_checks++;
        if (grants !== want) begin
            n_fail++; $display("FAIL starve_order: got %b want %b", grants, want);
        end
        n_checks++;
        if (dut.starve_q !== 3'd0) begin
            n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.starve_q);
        end
        n_checks++;
        if (conflict_cnt !== 32'd5) begin
            n_fail++; $display("FAIL starve_conflict: got %0d want 5", conflict_cnt);
        end
    endtask

    task automatic test_store();
        reset_dut();
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_2000;
        bus.ls_wen        = 1'b1;
        bus.ls_wmask      = 8'h0F;
        bus.ls_wdata      = 64'h1234;
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_wen !== 1'b1 || bus.mem_wmask !== 8'h0F ||
            bus.mem_wdata !== 64'h1234 || bus.ls_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL store_fwd: got wen %b mask %h data %h want 1 0f 1234",
                               bus.mem_wen, bus.mem_wmask, bus.mem_wdata);
        end
        tick();
        bus.ls_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hDEAD;
        #1;
        n_checks++;
        if (bus.ls_resp_valid !== 1'b1 || bus.if_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_ack: got ls %b if %b want 1 0",
                               bus.ls_resp_valid, bus.if_resp_valid);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_mem_stall();
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0040;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_4008;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0 ||
                busy !== 1'b0 || bus.mem_req_valid !== 1'b1 ||
                bus.mem_addr !== 64'h8000_4008) begin
                n_fail++; $display("FAIL stall%0d: got rdy %b%b busy %b addr %h want 00 0 80004008",
                                   i, bus.if_req_ready, bus.ls_req_ready, busy, bus.mem_addr);
            end
            tick();
        end
        n_checks++;
        if (conflict_cnt !== 32'd3) begin
            n_fail++; $display("FAIL stall_conflict: got %0d want 3", conflict_cnt);
        end
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got ls %b want 1", bus.ls_req_ready);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_5000;
        bus.mem_req_ready = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
            bus.ls_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got busy %b mreq %b want 0 0",
                               busy, bus.mem_req_valid);
        end
        bus.ls_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h5555_AAAA_5555_AAAA;
        #1;
        n_checks++;
        if (bus.ls_resp_valid !== 1'b0 || bus.if_resp_valid !== 1'b0 ||
            bus.ls_resp_data !== 64'd0 || bus.if_resp_data !== 32'd0) begin
            n_fail++; $display("FAIL mid_stray: got ls %b if %b want 0 0",
                               bus.ls_resp_valid, bus.if_resp_valid);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL mid_state: got busy %b cnt %0d want 0 0",
                               busy, conflict_cnt);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_if_only();
        test_simultaneous();
        test_starvation();
        test_store();
        test_mem_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
